rx_phyretrain: RTL and testbench

Receive-side partner of the PHYRETRAIN TX sub-FSM inside the LTSM PHYRETRAIN state. It consumes the partner's PHYRETRAIN start request from the decoded sideband stream and resolves the retrain encoding (local vs. remote). It answers with a PHYRETRAIN start response through the sideband wrapper, then signals completion to the LTSM. A timeout guards against a partner that never sends its request.

---
 rtl/rx_phyretrain.sv | 130 +++++++++++++
 tb/tb_rx_phyretrain.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_phyretrain.sv
// Receive-side PHYRETRAIN handshake: waits for the partner's START_REQ, resolves the
// retrain encoding against the local one, answers with START_RESP and reports completion.
module rx_phyretrain #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_phyretrain_en,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_rx_msg_valid,
  input  logic [2:0]              i_remote_msg_info,
  input  logic [2:0]              i_local_msg_info,
  input  logic                    i_falling_edge_busy,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic                    o_valid_rx,
  output logic [2:0]              o_resolved_state,
  output logic                    o_encoding_error,
  output logic                    o_phyretrain_end_rx,
  output logic                    o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_START_REQ  = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_START_RESP = SB_MSG_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    SEND_RESP,
    DONE,
    TIMEOUT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic       w_start_req;
  logic       w_expired;
  logic       w_capture;
  logic       w_remote_ok;
  logic [2:0] w_local;
  logic [2:0] w_remote;
  logic [2:0] w_merged;
  logic [2:0] w_resolved;

  assign w_start_req = i_rx_msg_valid && (i_decoded_SB_msg == MSG_START_REQ);
  assign w_expired   = (r_cnt == CNT_LAST);
  // Enable low always wins over a simultaneous request, so nothing is captured then.
  assign w_capture   = i_phyretrain_en && w_start_req &&
                       ((r_state == IDLE) || (r_state == WAIT_REQ));

  // Malformed encodings degrade to TXSELFCAL, the weakest retrain reason.
  always_comb begin
    w_remote_ok = $onehot(i_remote_msg_info);
    w_remote    = w_remote_ok ? i_remote_msg_info : 3'b001;
    w_local     = $onehot(i_local_msg_info) ? i_local_msg_info : 3'b001;
    w_merged    = w_local | w_remote;
    w_resolved  = 3'b001;
    if (w_merged[2])      w_resolved = 3'b100;
    else if (w_merged[1]) w_resolved = 3'b010;
  end

  // NOTE: sequential state uses non-blocking assignments only; where two assignments to
  // the same register fall in one pass (capture after the case), the later one wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state             <= IDLE;
      r_cnt               <= '0;
      o_encoded_SB_msg_rx <= '0;
      o_valid_rx          <= 1'b0;
      o_resolved_state    <= 3'b000;
      o_encoding_error    <= 1'b0;
      o_phyretrain_end_rx <= 1'b0;
      o_timeout           <= 1'b0;
    end else begin
      o_encoding_error <= 1'b0;
      if (!i_phyretrain_en) begin
        r_state             <= IDLE;
        r_cnt               <= '0;
        o_encoded_SB_msg_rx <= '0;
        o_valid_rx          <= 1'b0;
        o_resolved_state    <= 3'b000;
        o_phyretrain_end_rx <= 1'b0;
        o_timeout           <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt   <= '0;
            r_state <= w_start_req ? SEND_RESP : WAIT_REQ;
          end
          WAIT_REQ: begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            if (w_start_req) begin
              r_state <= SEND_RESP;
            end else if (w_expired) begin
              r_state    <= TIMEOUT;
              o_timeout  <= 1'b1;
              o_valid_rx <= 1'b0;
            end
          end
          SEND_RESP: begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            if (i_falling_edge_busy && o_valid_rx) begin
              r_state             <= DONE;
              o_valid_rx          <= 1'b0;
              o_phyretrain_end_rx <= 1'b1;
            end else if (w_expired) begin
              r_state    <= TIMEOUT;
              o_timeout  <= 1'b1;
              o_valid_rx <= 1'b0;
            end
          end
          DONE, TIMEOUT: ;
          default: r_state <= IDLE;
        endcase

        if (w_capture) begin
          o_resolved_state    <= w_resolved;
          o_encoded_SB_msg_rx <= MSG_START_RESP;
          o_valid_rx          <= 1'b1;
          o_encoding_error    <= !w_remote_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_phyretrain.sv
// Scoreboard bench for rx_phyretrain: stimulus pushes expected responses, a negedge
// monitor pops and compares them whenever the DUT raises its response valid.
module tb_rx_phyretrain;

  localparam int W  = 4;
  localparam int TO = 16;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_phyretrain_en;
  logic [W-1:0] i_decoded_SB_msg;
  logic         i_rx_msg_valid;
  logic [2:0]   i_remote_msg_info;
  logic [2:0]   i_local_msg_info;
  logic         i_falling_edge_busy;
  logic [W-1:0] o_encoded_SB_msg_rx;
  logic         o_valid_rx;
  logic [2:0]   o_resolved_state;
  logic         o_encoding_error;
  logic         o_phyretrain_end_rx;
  logic         o_timeout;

  rx_phyretrain #(.SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_phyretrain_en     (i_phyretrain_en),
    .i_decoded_SB_msg    (i_decoded_SB_msg),
    .i_rx_msg_valid      (i_rx_msg_valid),
    .i_remote_msg_info   (i_remote_msg_info),
    .i_local_msg_info    (i_local_msg_info),
    .i_falling_edge_busy (i_falling_edge_busy),
    .o_encoded_SB_msg_rx (o_encoded_SB_msg_rx),
    .o_valid_rx          (o_valid_rx),
    .o_resolved_state    (o_resolved_state),
    .o_encoding_error    (o_encoding_error),
    .o_phyretrain_end_rx (o_phyretrain_end_rx),
    .o_timeout           (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0] res;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: rank each encoding (non-one-hot counts as TXSELFCAL), response carries the max.
  function automatic int rank(input logic [2:0] e);
    if (e == 3'b100) return 3;
    if (e == 3'b010) return 2;
    return 1;
  endfunction

  function automatic exp_t model(input logic [2:0] loc, input logic [2:0] rem);
    exp_t e;
    int   r;
    r     = (rank(loc) > rank(rem)) ? rank(loc) : rank(rem);
    e.res = 3'(1 << (r - 1));
    e.err = !(rem == 3'b001 || rem == 3'b010 || rem == 3'b100);
    return e;
  endfunction

  // Monitor: compares each new response against the oldest expected entry.
  logic prev_valid = 1'b0;
  bit   err_check  = 1'b0;
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst_n) begin
      prev_valid = 1'b0;
      err_check  = 1'b0;
    end else begin
      if (err_check) begin
        check("err_pulse_width", 32'(o_encoding_error), 32'd0);
        err_check = 1'b0;
      end
      if (o_valid_rx && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("resp_msg", 32'(o_encoded_SB_msg_rx), 32'd2);
          check("resp_state", 32'(o_resolved_state), 32'(e.res));
          check("resp_err", 32'(o_encoding_error), 32'(e.err));
          err_check = 1'b1;
        end
      end
      prev_valid = o_valid_rx;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic noise();
    logic [W-1:0] m;
    m = W'($urandom_range(0, 15));
    if (m == W'(1)) m = W'(2);
    i_decoded_SB_msg  = m;
    i_rx_msg_valid    = 1'($urandom_range(0, 1));
    i_remote_msg_info = 3'($urandom_range(0, 7));
  endtask

  task automatic send_req(input logic [2:0] rem);
    i_decoded_SB_msg  = W'(1);
    i_rx_msg_valid    = 1'b1;
    i_remote_msg_info = rem;
  endtask

  function automatic logic [10:0] all_outs();
    return {o_valid_rx, o_encoded_SB_msg_rx, o_resolved_state,
            o_encoding_error, o_phyretrain_end_rx, o_timeout};
  endfunction

  // One full handshake: enable, optional wait with noise, request, optional wait, busy edge.
  task automatic txn(input logic [2:0] loc, input logic [2:0] rem,
                     input int d_req, input int d_busy);
    exp_t e;
    i_phyretrain_en = 1'b0;
    i_rx_msg_valid  = 1'b0;
    tick();
    e                = model(loc, rem);
    i_local_msg_info = loc;
    i_phyretrain_en  = 1'b1;
    for (int i = 0; i < d_req; i++) begin
      noise();
      tick();
    end
    sb_q.push_back(e);
    send_req(rem);
    tick();
    check("latency_valid", 32'(o_valid_rx), 32'd1);
    i_rx_msg_valid = 1'b0;
    for (int i = 0; i < d_busy; i++) begin
      if ($urandom_range(0, 1) == 1) send_req(3'($urandom_range(0, 7)));
      else noise();
      tick();
    end
    i_rx_msg_valid      = 1'b0;
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    check("done_end", 32'(o_phyretrain_end_rx), 32'd1);
    check("done_valid", 32'(o_valid_rx), 32'd0);
    check("done_state", 32'(o_resolved_state), 32'(e.res));
  endtask

  logic [2:0] dir_loc[5] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b010};
  logic [2:0] dir_rem[5] = '{3'b001, 3'b100, 3'b001, 3'b010, 3'b011};
  int         dir_dly[5] = '{3, 1, 2, 0, 2};

  initial begin
    i_rst_n             = 1'b0;
    i_phyretrain_en     = 1'b0;
    i_decoded_SB_msg    = '0;
    i_rx_msg_valid      = 1'b0;
    i_remote_msg_info   = 3'b000;
    i_local_msg_info    = 3'b000;
    i_falling_edge_busy = 1'b0;
    repeat (2) tick();
    check("reset_outputs", 32'(all_outs()), 32'd0);
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) txn(dir_loc[i], dir_rem[i], dir_dly[i], 1);

    for (int i = 0; i < 30; i++)
      txn(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          $urandom_range(0, 5), $urandom_range(0, 4));

    // Timeout with no request: flag rises on the 16th edge after entering WAIT_REQ.
    i_phyretrain_en = 1'b0;
    i_rx_msg_valid  = 1'b0;
    tick();
    i_phyretrain_en = 1'b1;
    tick();
    repeat (TO - 1) tick();
    check("timeout_early", 32'(o_timeout), 32'd0);
    tick();
    check("timeout_set", 32'(o_timeout), 32'd1);
    check("timeout_valid", 32'(o_valid_rx), 32'd0);
    tick();
    check("timeout_sticky", 32'(o_timeout), 32'd1);
    i_phyretrain_en = 1'b0;
    tick();
    check("timeout_clear", 32'(all_outs()), 32'd0);

    // Enable dropped while the response is pending.
    i_local_msg_info = 3'b010;
    i_phyretrain_en  = 1'b1;
    sb_q.push_back(model(3'b010, 3'b100));
    send_req(3'b100);
    tick();
    check("abort_valid_up", 32'(o_valid_rx), 32'd1);
    i_rx_msg_valid  = 1'b0;
    i_phyretrain_en = 1'b0;
    tick();
    check("abort_outputs", 32'(all_outs()), 32'd0);
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    check("abort_late_busy", 32'(o_phyretrain_end_rx), 32'd0);

    // DONE ignores a second request; async reset clears outputs before the next edge.
    txn(3'b100, 3'b001, 1, 1);
    send_req(3'b010);
    tick();
    i_rx_msg_valid = 1'b0;
    check("done_req_end", 32'(o_phyretrain_end_rx), 32'd1);
    check("done_req_valid", 32'(o_valid_rx), 32'd0);
    check("done_req_state", 32'(o_resolved_state), 32'd4);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_reset", 32'(all_outs()), 32'd0);
    i_phyretrain_en = 1'b0;
    #1;
    i_rst_n = 1'b1;
    repeat (2) tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
